// File: rtl/twiddle_mul_sched_if.sv
// twiddle_mul_sched_if: sample stream, twiddle ROM and multiplier signals of the twiddle scheduler
interface twiddle_mul_sched_if #(parameter int N_LOG2 = 4, parameter int DW = 24);
  logic start;
  logic [N_LOG2-1:0] stage;
  logic in_valid;
  logic in_ready;
  logic [DW-1:0] in_data;
  logic rom_en;
  logic [N_LOG2-2:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] mul_c;
  logic [DW-1:0] mul_t;
  logic [DW-1:0] mul_out;
  logic out_valid;
  logic out_ready;
  logic [DW-1:0] out_data;
  logic out_last;
  logic busy;
  logic done;
  modport slave (
    input start, stage, in_valid, in_data, rom_data, mul_out, out_ready,
    output in_ready, rom_en, rom_addr, mul_c, mul_t, out_valid, out_data, out_last, busy, done
  );
  modport master (
    output start, stage, in_valid, in_data, rom_data, mul_out, out_ready,
    input in_ready, rom_en, rom_addr, mul_c, mul_t, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/twiddle_mul_sched.sv
// twiddle_mul_sched: streams one FFT-stage frame through the shared twiddle multiplier
module twiddle_mul_sched #(
  parameter int N_LOG2 = 4,
  parameter int DW = 24
) (
  input logic clk,
  input logic rst_n,
  twiddle_mul_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [N_LOG2-1:0] j, s, mask, idx;
  logic b_valid, b_last;
  logic [DW-1:0] b_data;
  logic advance, accept, last_hs;
  assign advance = !(bus.out_valid && !bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign last_hs = bus.out_valid && bus.out_ready && bus.out_last;
  assign mask = N_LOG2'((32'd1 << s) - 32'd1);
  assign idx = (j & mask) << (N_LOG2 - 1 - int'(s));
  assign bus.rom_addr = idx[N_LOG2-2:0];
  assign bus.mul_c = b_data;
  assign bus.mul_t = bus.rom_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = RUN;
      RUN: if (accept && &j) state_nx = DRAIN;
      DRAIN: if (last_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready = (state == RUN) && advance;
    bus.busy = state != IDLE;
    bus.rom_en = bus.in_valid && (state == RUN) && advance;
  end
  // rom_en drops on stall, so rom_data and stage B stay aligned until release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      j <= '0;
      s <= '0;
      b_valid <= 1'b0;
      b_last <= 1'b0;
      b_data <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last <= 1'b0;
      bus.out_data <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= (state == DRAIN) && last_hs;
      if (state == IDLE && bus.start) begin
        s <= (int'(bus.stage) >= N_LOG2) ? N_LOG2'(N_LOG2 - 1) : bus.stage;
        j <= '0;
      end else if (accept) j <= j + 1'b1;
      if (accept) begin
        b_data <= bus.in_data;
        b_last <= &j;
      end
      if (advance) begin
        b_valid <= accept;
        bus.out_valid <= b_valid;
        bus.out_last <= b_valid && b_last;
        if (b_valid) bus.out_data <= bus.mul_out;
      end
    end
endmodule

// File: tb/tb_twiddle_mul_sched.sv
// tb_twiddle_mul_sched: random frames against a queue-based reference of the twiddle products
module tb_twiddle_mul_sched;
  localparam int NL = 4, DW = 24, N = 1 << NL;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  twiddle_mul_sched_if #(.N_LOG2(NL), .DW(DW)) bus();
  twiddle_mul_sched #(.N_LOG2(NL), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [DW-1:0] rom [N/2];
  always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
  assign bus.mul_out = bus.mul_c ^ bus.mul_t;
  typedef struct {logic [DW-1:0] d; logic l;} exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0;
  int cyc = 0, m_j = 0, m_s = 0, n_prod = 0, n_last = 0, n_done = 0;
  int first_acc = -1, first_ov = -1, last_hs_cyc = 0, stall_req = 0;
  bit lat_arm = 0, bp_arm = 0, rnd_ready = 0, prev_stall = 0;
  logic [DW-1:0] prev_data;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int tw_idx(input int jj, input int ss);
    return (jj % (1 << ss)) * (1 << (NL - 1 - ss));
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n) begin
    if (prev_stall) chk("stall_hold", bus.out_data, prev_data);
    if (bus.out_valid && !bus.out_ready) begin
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_rom_en", bus.rom_en, 0);
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data = bus.out_data;
    if (bus.in_valid && bus.in_ready) begin
      chk("rom_en", bus.rom_en, 1);
      chk("rom_addr", bus.rom_addr, tw_idx(m_j, m_s));
      q.push_back('{d: bus.in_data ^ rom[tw_idx(m_j, m_s)], l: m_j == N - 1});
      if (lat_arm && first_acc < 0) first_acc = cyc;
      if (bp_arm && m_j == 6) stall_req = 3;
      m_j++;
    end
    if (bus.out_valid && lat_arm && first_ov < 0) begin
      first_ov = cyc;
      chk("latency", first_ov - first_acc, 2);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) chk("extra_product", 1, 0);
      else begin
        e = q.pop_front();
        chk("out_data", bus.out_data, e.d);
        chk("out_last", bus.out_last, e.l);
      end
      n_prod++;
      if (bus.out_last) begin
        n_last++;
        last_hs_cyc = cyc;
      end
    end
    if (bus.done) begin
      n_done++;
      chk("done_delay", cyc - last_hs_cyc, 1);
      chk("busy_at_done", bus.busy, 0);
    end
  end
  initial begin
    bus.out_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req > 0) begin
        bus.out_ready = 0;
        stall_req--;
      end else bus.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end
  task automatic start_frame(input int st);
    bus.stage = NL'(st);
    bus.start = 1;
    m_j = 0;
    m_s = (st >= NL) ? NL - 1 : st;
    @(posedge clk);
    #1;
    bus.start = 0;
  endtask
  task automatic send(input int cnt, input bit gaps, input int start_at);
    bit hs;
    int t;
    for (int i = 0; i < cnt; i++) begin
      if (gaps) begin
        bus.in_valid = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      bus.in_valid = 1;
      bus.in_data = DW'($urandom);
      if (i == start_at) begin
        bus.stage = 0;
        bus.start = 1;
      end
      t = 0;
      hs = 0;
      while (!hs && t < 500) begin
        @(negedge clk);
        hs = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
        bus.start = 0;
        t++;
      end
      if (!hs) chk("accept_timeout", 0, 1);
    end
    bus.in_valid = 0;
  endtask
  task automatic wait_done();
    int t = 0;
    do begin @(negedge clk); t++; end while (!bus.done && t < 500);
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask
  task automatic full_frame(input int st, input bit gaps);
    int p0, l0, d0;
    p0 = n_prod; l0 = n_last; d0 = n_done;
    start_frame(st);
    send(N, gaps, -1);
    wait_done();
    repeat (3) @(negedge clk);
    chk("frame_products", n_prod - p0, N);
    chk("frame_lasts", n_last - l0, 1);
    chk("frame_dones", n_done - d0, 1);
    chk("queue_empty", q.size(), 0);
    chk("busy_idle", bus.busy, 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int d0, p0, l0;
    for (int i = 0; i < N / 2; i++) rom[i] = DW'($urandom);
    bus.start = 0; bus.stage = 0; bus.in_valid = 0; bus.in_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rom_en", bus.rom_en, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    start_frame(3);
    send(5, 0, -1);
    d0 = n_done;
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_out_last", bus.out_last, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_rom_en", bus.rom_en, 0);
    chk("mid_rst_rom_addr", bus.rom_addr, 0);
    chk("mid_rst_mul_c", bus.mul_c, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    q.delete();
    prev_stall = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_no_done", n_done - d0, 0);
    lat_arm = 1;
    full_frame(3, 0);
    lat_arm = 0;
    rnd_ready = 1;
    full_frame(1, 1);
    full_frame(0, 1);
    full_frame(7, 1);
    rnd_ready = 0;
    bp_arm = 1;
    full_frame(3, 0);
    bp_arm = 0;
    rnd_ready = 1;
    p0 = n_prod; d0 = n_done;
    start_frame(2);
    send(N, 1, 9);
    wait_done();
    repeat (5) @(negedge clk);
    chk("restart_ignored_products", n_prod - p0, N);
    chk("restart_ignored_dones", n_done - d0, 1);
    @(posedge clk);
    #1;
    p0 = n_prod; l0 = n_last; d0 = n_done;
    start_frame(2);
    send(N, 1, -1);
    wait_done();
    start_frame(3);
    send(N, 1, -1);
    wait_done();
    repeat (3) @(negedge clk);
    chk("b2b_products", n_prod - p0, 2 * N);
    chk("b2b_lasts", n_last - l0, 2);
    chk("b2b_dones", n_done - d0, 2);
    chk("b2b_queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
